alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared NBits ALU. Two requesters submit an operation, two operands and a carry option through valid/ready handshakes. The block grants one request at a time in round-robin order and holds the registered operands on the ALU for one execute cycle. It then captures the result and flags and returns them on a single valid/ready response channel tagged with the requester ID. It also keeps a per-requester carry flag so multi-word add/subtract chains can run without requester-side state.

## Interface
- NBits, 8, operand/result width (matches ALU)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  ALU selection code
- req0_a, req0_b / req1_a, req1_b  in  NBits  operands
- req0_cin / req1_cin  in  1  explicit carry-in
- req0_use_c / req1_use_c  in  1  1 = use the stored carry flag of this requester instead of reqN_cin
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  NBits  ALU result
- rsp_flags  out  4  {negative, zero, carry_out, overflow}
- rsp_err  out  1  illegal opcode
- alu_selection  out  4  to ALU selection
- alu_a, alu_b  out  NBits  to ALU A/B
- alu_carry_in  out  1  to ALU carry_in
- alu_result  in  NBits  from ALU
- alu_zero, alu_overflow, alu_negative, alu_carry_out  in  1  from ALU flags

## Operation
- Legal opcodes are 0 to 8: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 xor, 6 sll, 7 srl, 8 sra. Opcodes 9 to 15 are illegal.
- FSM states: IDLE, EXEC, RESP.
- **IDLE, grant:** the grant is combinational.
  - Only one valid: grant it.
  - Both valid: grant the requester opposite to last_grant.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high.
- **IDLE, on handshake with a legal op:**
  - Register op, a and b into alu_selection, alu_a and alu_b.
  - alu_carry_in <= use_c ? cflagN : cin.
  - Record id and last_grant <= N.
  - Go to EXEC.
- **IDLE, on handshake with an illegal op:**
  - ALU outputs are not updated.
  - rsp_result = 0, rsp_flags = 0, rsp_err = 1, rsp_id = N, last_grant <= N.
  - Go directly to RESP.
- **EXEC:** lasts one cycle while the ALU settles.
  - At the closing edge, capture alu_result and {alu_negative, alu_zero, alu_carry_out, alu_overflow} into the rsp registers, with rsp_err = 0.
  - cflag[id] <= alu_carry_out, for every legal op.
  - Go to RESP.
- **RESP:**
  - rsp_valid = 1. All rsp_* outputs are stable until the handshake.
  - When rsp_valid & rsp_ready at an edge, go to IDLE. The next grant can be issued in that following IDLE cycle.
- ALU drive outputs hold their last registered values in every state.
- Each requester's cflag is independent. It changes only on a legal op from that requester.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE, last_grant = 1 (req0 wins the first tie).
  - cflag0 = cflag1 = 0.
  - All ALU drive outputs = 0.
  - rsp_valid = 0; rsp_id, rsp_result, rsp_flags and rsp_err = 0.
  - req ready outputs = 0 while rst_n is low.
- Legal op latency:
  - Handshake at edge T.
  - EXEC spans T to T+1.
  - rsp_valid rises after edge T+1.
  - With rsp_ready held high, the response completes at edge T+2 and the next grant is possible in the cycle after T+2.
  - Throughput is 1 op per 3 cycles.
- Illegal op latency: rsp_valid rises after the handshake edge, so the sequence is 2 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. Both reqN_ready stay 0 throughout.
- Request arriving in EXEC or RESP: waits with ready low. The requester must keep valid and its payload stable until ready.
- Reset mid-operation: returns immediately to IDLE and drops rsp_valid. The pending operation is lost and cflags are cleared.
- A single requester with valid held continuously is granted back-to-back every 3 cycles, with no starvation gap.

## Test plan
- Reset release, req0 add A=0x05 B=0x03 cin=0 -> rsp_valid 2 cycles after handshake, id=0, result=0x08, flags N0 Z0 C0 V0, err=0.
- Carry chain: req1 add 0xFF+0x01 cin=0 -> result 0x00, flags Z=1 C=1. Then req1 add 0x00+0x00 use_c=1 -> result 0x01 and alu_carry_in observed = 1. Interleaved req0 add with use_c=1 drives alu_carry_in = 0, proving independent cflags.
- Both valid every cycle after reset -> grants alternate 0,1,0,1. rsp_id sequence matches. Never both readys high.
- Illegal op 0xC from req0 -> rsp_err=1, result 0, flags 0 one cycle after handshake. ALU drive outputs unchanged. cflag0 unchanged.
- rsp_ready low for 5 cycles in RESP -> rsp_* stable, both readys 0. Release -> handshake completes and the next grant follows one cycle later.
- rst_n pulled low during EXEC -> rsp_valid 0 and alu_* outputs 0 immediately. After release, an sra 0x80 by 1 returns 0xC0 with N=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer for a shared NBits ALU.
//
// Two requesters each present {op, a, b, cin, use_c} on a valid/ready
// handshake. One request is granted at a time. Legal ops spend one EXEC
// cycle on the ALU, and the result and flags are then returned on a single
// valid/ready response channel tagged with the requester id. Illegal ops
// (9..15) skip the ALU and respond with rsp_err. A carry flag is kept for
// each requester so that multi-word add/sub chains can use use_c.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     request handshake, N = 0, 1
//   reqN_op, reqN_a, reqN_b     ALU selection code and operands
//   reqN_cin, reqN_use_c        explicit carry-in / use this requester's stored carry
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result          issuing requester, ALU result
//   rsp_flags                   {negative, zero, carry_out, overflow}
//   rsp_err                     illegal opcode
//   alu_selection/a/b/carry_in  registered drive to the ALU
//   alu_result, alu_*           ALU result and flags
module alu_arbiter #(
  parameter int NBits = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [NBits-1:0] req0_a,
  input  logic [NBits-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_use_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [NBits-1:0] req1_a,
  input  logic [NBits-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_use_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [NBits-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [3:0]       alu_selection,
  output logic [NBits-1:0] alu_a,
  output logic [NBits-1:0] alu_b,
  output logic             alu_carry_in,
  input  logic [NBits-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_carry_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic [1:0]       r_cflag;
  logic [3:0]       r_sel;
  logic [NBits-1:0] r_a;
  logic [NBits-1:0] r_b;
  logic             r_cin;
  logic             r_rsp_id;
  logic [NBits-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_hs;
  logic             w_gid;
  logic             w_legal;
  logic             w_cin;
  logic [3:0]       w_op;
  logic [NBits-1:0] w_a;
  logic [NBits-1:0] w_b;

  // Grant and payload mux. When both requesters are valid, the one that was
  // not granted last time wins. Ready is gated by rst_n so that it stays low
  // while reset is asserted.
  always_comb begin
    w_grant0   = req0_valid & (~req1_valid | r_last_grant);
    w_grant1   = req1_valid & (~req0_valid | ~r_last_grant);
    req0_ready = rst_n & (r_state == IDLE) & w_grant0;
    req1_ready = rst_n & (r_state == IDLE) & w_grant1;
    w_hs       = req0_ready | req1_ready;
    w_gid      = req1_ready;
    w_op       = w_gid ? req1_op : req0_op;
    w_a        = w_gid ? req1_a  : req0_a;
    w_b        = w_gid ? req1_b  : req0_b;
    w_cin      = w_gid ? (req1_use_c ? r_cflag[1] : req1_cin)
                       : (req0_use_c ? r_cflag[0] : req0_cin);
    w_legal    = (w_op <= 4'd8);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = w_legal ? EXEC : RESP;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // rsp_id is written at grant time for both legal and illegal ops. During
  // EXEC it therefore already identifies the owner of the carry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cflag      <= '0;
      r_sel        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_last_grant <= w_gid;
            r_rsp_id     <= w_gid;
            if (w_legal) begin
              r_sel <= w_op;
              r_a   <= w_a;
              r_b   <= w_b;
              r_cin <= w_cin;
            end else begin
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
              r_rsp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_rsp_result      <= alu_result;
          r_rsp_flags       <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
          r_rsp_err         <= 1'b0;
          r_cflag[r_rsp_id] <= alu_carry_out;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid     = (r_state == RESP);
  assign rsp_id        = r_rsp_id;
  assign rsp_result    = r_rsp_result;
  assign rsp_flags     = r_rsp_flags;
  assign rsp_err       = r_rsp_err;
  assign alu_selection = r_sel;
  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_carry_in  = r_cin;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. A behavioural ALU stub answers the DUT's ALU
// port. A transaction-level model predicts each grant and response, and a
// monitor compares DUT responses against the queued expectations.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req1_cin, req0_use_c, req1_use_c;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] alu_selection;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_carry_in, alu_zero, alu_overflow, alu_negative, alu_carry_out;

  always #5 clk = ~clk;

  // requester-side state: payload is held until the grant is seen
  logic       p_valid[2];
  logic [3:0] p_op[2];
  logic [7:0] p_a[2], p_b[2];
  logic       p_cin[2], p_usec[2];
  bit         taken[2];

  assign req0_valid = p_valid[0];  assign req1_valid = p_valid[1];
  assign req0_op    = p_op[0];     assign req1_op    = p_op[1];
  assign req0_a     = p_a[0];      assign req1_a     = p_a[1];
  assign req0_b     = p_b[0];      assign req1_b     = p_b[1];
  assign req0_cin   = p_cin[0];    assign req1_cin   = p_cin[1];
  assign req0_use_c = p_usec[0];   assign req1_use_c = p_usec[1];

  alu_arbiter #(.NBits(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_use_c(req0_use_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_use_c(req1_use_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_selection(alu_selection), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative), .alu_carry_out(alu_carry_out)
  );

  // Reference ALU: returns {result[7:0], N, Z, C, V}
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + {8'd0, ci};
        r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = a ^ b;
      4'd6: r = a << b[2:0];
      4'd7: r = a >> b[2:0];
      4'd8: r = 8'($signed(a) >>> b[2:0]);
      default: r = '0;
    endcase
    return {r, r[7], (r == 8'd0), c, v};
  endfunction

  logic [11:0] alu_out;
  always_comb alu_out = alu_fn(alu_selection, alu_a, alu_b, alu_carry_in);
  assign alu_result    = alu_out[11:4];
  assign alu_negative  = alu_out[3];
  assign alu_zero      = alu_out[2];
  assign alu_carry_out = alu_out[1];
  assign alu_overflow  = alu_out[0];

  typedef struct {
    logic       id;
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;
    int         hs;
    int         lat;
  } exp_t;

  exp_t        exp_q[$];
  logic        m_last;
  logic        m_cflag[2];
  logic [20:0] m_alu;
  bit          chk_pend, seen_valid;
  int          chk_cyc;
  int          cyc = 0;
  int          checks = 0, failures = 0;
  bit          rnd = 0, rnd_rdy = 0;
  int          prob = 0, ill_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = 1'b1; m_cflag[0] = 1'b0; m_cflag[1] = 1'b0; m_alu = '0;
    chk_pend = 0; seen_valid = 0; taken[0] = 0; taken[1] = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sampled at the negedge: predicts grants, queues expectations, checks responses.
  task automatic observe();
    bit          busy, has_g;
    int          g;
    logic        ce;
    logic [11:0] o;
    exp_t        e;
    busy = (exp_q.size() != 0);
    if (chk_pend && cyc == chk_cyc) begin
      chk("alu_drive", 32'({alu_selection, alu_a, alu_b, alu_carry_in}), 32'(m_alu));
      chk_pend = 0;
    end
    has_g = 0; g = 0;
    if (!busy) begin
      if (p_valid[0] && p_valid[1]) begin has_g = 1; g = m_last ? 0 : 1; end
      else if (p_valid[0])          begin has_g = 1; g = 0; end
      else if (p_valid[1])          begin has_g = 1; g = 1; end
    end
    chk("ready", 32'({req1_ready, req0_ready}), has_g ? (32'd1 << g) : 32'd0);
    if (has_g) begin
      taken[g] = 1;
      m_last   = g[0];
      e.id     = g[0];
      e.hs     = cyc + 1;
      if (p_op[g] <= 4'd8) begin
        ce       = p_usec[g] ? m_cflag[g] : p_cin[g];
        o        = alu_fn(p_op[g], p_a[g], p_b[g], ce);
        e.result = o[11:4]; e.flags = o[3:0]; e.err = 1'b0; e.lat = 1;
        m_cflag[g] = o[1];
        m_alu      = {p_op[g], p_a[g], p_b[g], ce};
      end else begin
        e.result = '0; e.flags = '0; e.err = 1'b1; e.lat = 0;
      end
      chk_pend = 1; chk_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    if (!busy) begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end else begin
      e = exp_q[0];
      if (rsp_valid) begin
        if (!seen_valid) begin
          chk("rsp_latency", 32'(cyc - e.hs), 32'(e.lat));
          seen_valid = 1;
        end
        chk("rsp_payload", 32'({rsp_id, rsp_result, rsp_flags, rsp_err}),
            32'({e.id, e.result, e.flags, e.err}));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          seen_valid = 0;
        end
      end else if (seen_valid || cyc >= e.hs + e.lat) begin
        chk("rsp_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
        seen_valid = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) observe();
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (taken[n]) begin taken[n] = 0; p_valid[n] = 1'b0; end
      if (rnd && !p_valid[n] && $urandom_range(0, 99) < prob) begin
        p_valid[n] = 1'b1;
        p_op[n]    = ($urandom_range(0, 99) < ill_pct) ? 4'($urandom_range(9, 15))
                                                       : 4'($urandom_range(0, 8));
        p_a[n]     = 8'($urandom);
        p_b[n]     = 8'($urandom);
        p_cin[n]   = 1'($urandom);
        p_usec[n]  = 1'($urandom);
      end
    end
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load(input int n, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic ci, input logic uc);
    p_op[n] = op; p_a[n] = a; p_b[n] = b; p_cin[n] = ci; p_usec[n] = uc;
    p_valid[n] = 1'b1;
  endtask

  task automatic wait_taken(input int n);
    for (int i = 0; i < 40 && p_valid[n]; i++) step();
    if (p_valid[n]) begin
      chk("grant_timeout", 32'd0, 32'd1);
      p_valid[n] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || p_valid[0] || p_valid[1]); i++) step();
    if (exp_q.size() != 0 || p_valid[0] || p_valid[1]) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete(); p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    end
  endtask

  task automatic req(input int n, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic ci, input logic uc);
    load(n, op, a, b, ci, uc);
    wait_taken(n);
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      p_valid[n] = 1'b1; p_op[n] = '0; p_a[n] = '0; p_b[n] = '0;
      p_cin[n] = 1'b0; p_usec[n] = 1'b0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
    chk("rst_alu", 32'({alu_selection, alu_a, alu_b, alu_carry_in}), 32'd0);
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // basic add, then carry chain with independent flags
    rsp_ready = 1'b1;
    req(0, 4'd0, 8'h05, 8'h03, 1'b0, 1'b0);
    req(1, 4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    req(0, 4'd0, 8'h10, 8'h20, 1'b1, 1'b1);
    chk("cflag0_cin", 32'(alu_carry_in), 32'd0);
    req(1, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("cflag1_cin", 32'(alu_carry_in), 32'd1);

    // illegal opcode: ALU drive must hold the previous operation
    req(0, 4'hC, 8'h77, 8'h11, 1'b1, 1'b0);
    chk("illegal_alu_hold", 32'({alu_selection, alu_a, alu_b, alu_carry_in}),
        32'({4'd0, 8'h00, 8'h00, 1'b1}));

    // both requesters valid every cycle: grants must alternate
    rnd = 1; prob = 100; ill_pct = 0;
    repeat (24) step();
    rnd = 0;
    wait_idle();

    // backpressure with a second requester waiting
    rsp_ready = 1'b0;
    load(0, 4'd3, 8'h0F, 8'hA0, 1'b0, 1'b0);
    wait_taken(0);
    load(1, 4'd5, 8'h3C, 8'hFF, 1'b0, 1'b0);
    repeat (6) step();
    rsp_ready = 1'b1;
    wait_idle();

    // randomized traffic with random backpressure and some illegal ops
    rnd = 1; rnd_rdy = 1; prob = 40; ill_pct = 10;
    repeat (400) step();
    rnd = 0; rnd_rdy = 0; rsp_ready = 1'b1;
    wait_idle();

    // reset while in EXEC
    load(0, 4'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    wait_taken(0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_alu", 32'({alu_selection, alu_a, alu_b, alu_carry_in}), 32'd0);
    chk("midrst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    model_reset();
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    req(0, 4'd8, 8'h80, 8'h01, 1'b0, 1'b0);
    chk("sra_alu_result", 32'({alu_result, alu_negative}), 32'({8'hC0, 1'b1}));

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
